// File: rtl/occupancy_sensor_conditioner_pkg.sv
// Shared types and widths for the lighting controller sensor front end.
package lighting_pkg;

    localparam int OCC_STATE_W = 2;
    localparam int AMBIENT_W   = 8;

    typedef enum logic [OCC_STATE_W-1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/occupancy_sensor_conditioner_if.sv
// Sensor inputs and qualifier outputs between the sensor board and the conditioner.
interface occupancy_sensor_conditioner_if;
    import lighting_pkg::*;

    logic                   pir_raw;
    logic [AMBIENT_W-1:0]   ambient_level;
    logic                   ambient_valid;
    logic                   movement;
    logic                   dark;
    logic [OCC_STATE_W-1:0] occ_state;

    modport master (
        output pir_raw, ambient_level, ambient_valid,
        input  movement, dark, occ_state
    );

    modport slave (
        input  pir_raw, ambient_level, ambient_valid,
        output movement, dark, occ_state
    );

endinterface

// File: rtl/occupancy_sensor_conditioner_sensor_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer on a single asynchronous input.
module sensor_debounce #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [1:0]       sync;
    logic             clean_q;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             commit;

    assign differ = sync[1] ^ clean_q;
    assign commit = differ && (cnt == CNT_LAST);
    // dout is the level being committed on the coming edge, so a consumer
    // registering it changes state on the same edge as the debounced level.
    assign dout   = commit ? sync[1] : clean_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= '0;
            clean_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], din};
            clean_q <= dout;
            cnt     <= (differ && !commit) ? cnt + CNT_W'(1) : '0;
        end
    end

endmodule

// File: rtl/occupancy_sensor_conditioner.sv
// Sensor front end: debounced PIR with occupancy hold timer, and hysteretic
// N-sample confirmed darkness qualifier.
module occupancy_sensor_conditioner
    import lighting_pkg::*;
#(
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter int                   HOLD_CYCLES     = 1000,
    parameter logic [AMBIENT_W-1:0] DARK_ON_LEVEL   = 8'd60,
    parameter logic [AMBIENT_W-1:0] DARK_OFF_LEVEL  = 8'd90,
    parameter int                   CONFIRM_SAMPLES = 3
) (
    input logic clk,
    input logic rst_n,
    occupancy_sensor_conditioner_if.slave bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CONF_W = $clog2(CONFIRM_SAMPLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_SAMPLES - 1);
    localparam logic [CONF_W-1:0] CONF_MAX  = CONF_W'(CONFIRM_SAMPLES);

    localparam logic [OCC_STATE_W-1:0] ST_IDLE   = OCC_STATE_W'(IDLE);
    localparam logic [OCC_STATE_W-1:0] ST_ACTIVE = OCC_STATE_W'(ACTIVE);
    localparam logic [OCC_STATE_W-1:0] ST_HOLD   = OCC_STATE_W'(HOLD);

    generate
        if (DARK_OFF_LEVEL <= DARK_ON_LEVEL) begin : g_bad_thresholds
            $error("DARK_OFF_LEVEL must exceed DARK_ON_LEVEL");
        end
    endgenerate

    logic                   pir_clean;
    logic [OCC_STATE_W-1:0] state, state_nxt;
    logic [HOLD_W-1:0]      hold_cnt, hold_nxt;
    logic                   mov_q;
    logic                   dark_q;
    logic [CONF_W-1:0]      conf_cnt;
    logic                   qualify;

    sensor_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_pir_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.pir_raw),
        .dout  (pir_clean)
    );

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (pir_clean) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!pir_clean) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (pir_clean) begin
                    state_nxt = ST_ACTIVE;
                    hold_nxt  = '0;
                end else if (hold_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    hold_nxt  = hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // movement is its own flop so the output never sees a state-decode glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            mov_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            mov_q    <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_HOLD);
        end
    end

    // The qualifying direction flips with dark, giving the hysteresis band.
    always_comb begin
        qualify = dark_q ? (bus.ambient_level > DARK_OFF_LEVEL)
                         : (bus.ambient_level < DARK_ON_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dark_q   <= 1'b0;
            conf_cnt <= '0;
        end else if (bus.ambient_valid) begin
            if (!qualify) begin
                conf_cnt <= '0;
            end else if (conf_cnt == CONF_LAST) begin
                dark_q   <= ~dark_q;
                conf_cnt <= '0;
            end else if (conf_cnt != CONF_MAX) begin
                conf_cnt <= conf_cnt + CONF_W'(1);
            end
        end
    end

    assign bus.movement  = mov_q;
    assign bus.dark      = dark_q;
    assign bus.occ_state = state;

endmodule

// File: tb/tb_occupancy_sensor_conditioner.sv
// Scoreboard bench: a cycle-level reference model predicts the three outputs
// after every edge; a monitor pops and compares, plus directed spot checks.
module tb_occupancy_sensor_conditioner;
    import lighting_pkg::*;

    localparam int D = 4;
    localparam int H = 20;
    localparam int C = 3;
    localparam int ON_LVL  = 60;
    localparam int OFF_LVL = 90;

    typedef struct packed {
        logic       mov;
        logic       dark;
        logic [1:0] occ;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    occupancy_sensor_conditioner_if bus();

    occupancy_sensor_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .DARK_ON_LEVEL   (8'(ON_LVL)),
        .DARK_OFF_LEVEL  (8'(OFF_LVL)),
        .CONFIRM_SAMPLES (C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: sync pipe as a 2-deep delay, debounce as a run length of
    // disagreeing samples, occupancy as "edges since pir_clean was last high".
    int m_s1, m_s2, m_clean, m_run, m_since, m_dark, m_streak;

    function automatic void model_reset();
        m_s1 = 0; m_s2 = 0; m_clean = 0; m_run = 0;
        m_since = H + 1; m_dark = 0; m_streak = 0;
    endfunction

    function automatic void model_step(input logic r, input logic p, input int lvl, input logic v);
        int sample;
        bit qual;
        exp_t e;
        if (!r) begin
            model_reset();
        end else begin
            sample = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(p);
            if (sample != m_clean) begin
                m_run++;
                if (m_run == D) begin
                    m_clean = sample;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (m_clean == 1) m_since = 0;
            else if (m_since <= H) m_since++;
            if (v) begin
                qual = (m_dark == 1) ? (lvl > OFF_LVL) : (lvl < ON_LVL);
                if (qual) begin
                    m_streak++;
                    if (m_streak == C) begin
                        m_dark = 1 - m_dark;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
        end
        e.mov  = (m_since <= H);
        e.dark = (m_dark == 1);
        e.occ  = (m_since == 0) ? 2'd0 + 2'd1 : ((m_since <= H) ? 2'd2 : 2'd0);
        exp_q.push_back(e);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({bus.movement, bus.dark, bus.occ_state} !== e) begin
                    failures++;
                    if (failures <= 20)
                        $display("FAIL scoreboard t=%0t got mov=%b dark=%b occ=%0d want mov=%b dark=%b occ=%0d",
                                 $time, bus.movement, bus.dark, bus.occ_state, e.mov, e.dark, e.occ);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic p, input int lvl, input logic v);
        @(negedge clk);
        rst_n             = r;
        bus.pir_raw       = p;
        bus.ambient_level = 8'(lvl);
        bus.ambient_valid = v;
        model_step(r, p, lvl, v);
        @(posedge clk);
        #3;
    endtask

    task automatic idle(input int n, input logic p);
        for (int i = 0; i < n; i++) step(1'b1, p, 0, 1'b0);
    endtask

    task automatic amb(input int lvl);
        step(1'b1, 1'b0, lvl, 1'b1);
    endtask

    task automatic wait_hold(input string name);
        int n = 0;
        while (bus.occ_state != 2'd2 && n < 30) begin
            idle(1, 1'b0);
            n++;
        end
        if (n >= 30) chk(name, int'(bus.occ_state), 2);
    endtask

    task automatic count_hold(input string name);
        int cnt = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1, 1'b0);
            if (bus.occ_state == 2'd2 && bus.movement) cnt++;
        end
        chk(name, cnt, H);
        chk({name, "_idle"}, int'(bus.movement), 0);
    endtask

    initial begin : stim
        logic cur_pir;
        int   lvl, sel;
        rst_n = 1'b0;
        bus.pir_raw = 1'b0;
        bus.ambient_level = '0;
        bus.ambient_valid = 1'b0;
        model_reset();

        // 1: reset dominates a high PIR and dark-qualifying samples
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 0, 1'b1);
            chk("rst_mov", int'(bus.movement), 0);
            chk("rst_dark", int'(bus.dark), 0);
            chk("rst_occ", int'(bus.occ_state), 0);
        end
        idle(5, 1'b1);
        chk("rel_mov_e5", int'(bus.movement), 0);
        idle(1, 1'b1);
        chk("rel_mov_e6", int'(bus.movement), 1);
        idle(30, 1'b0);
        chk("rel_back_idle", int'(bus.occ_state), 0);

        // 2: short pulses are rejected, a 6-cycle pulse passes at edge 6
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                idle(1, 1'b1);
                chk("deb_short", int'(bus.movement), 0);
            end
            idle(1, 1'b0);
            chk("deb_short", int'(bus.movement), 0);
        end
        idle(6, 1'b0);
        idle(5, 1'b1);
        chk("deb_long_e5", int'(bus.movement), 0);
        idle(1, 1'b1);
        chk("deb_long_e6", int'(bus.movement), 1);
        chk("deb_long_occ", int'(bus.occ_state), 1);

        // 3: hold length, then retrigger inside the hold window
        idle(2, 1'b1);
        count_hold("hold_len");
        idle(8, 1'b1);
        wait_hold("hold_enter");
        idle(8, 1'b0);
        idle(5, 1'b1);
        chk("retrig_still_hold", int'(bus.occ_state), 2);
        idle(1, 1'b1);
        chk("retrig_active", int'(bus.occ_state), 1);
        count_hold("hold_len_retrig");

        // 4: confirm count resets on a non-qualifying sample
        amb(50); amb(50); amb(70); amb(50); amb(50);
        chk("dark_after_70", int'(bus.dark), 0);
        amb(50);
        chk("dark_on", int'(bus.dark), 1);
        amb(95); amb(95);
        chk("dark_off_2", int'(bus.dark), 1);
        amb(95);
        chk("dark_off", int'(bus.dark), 0);

        // 5: thresholds themselves and the band never qualify; gaps keep the count
        amb(60); amb(60); amb(60);
        chk("thr_on_eq", int'(bus.dark), 0);
        amb(50); amb(50); amb(50);
        chk("dark_on2", int'(bus.dark), 1);
        amb(90); amb(75); amb(90);
        chk("thr_off_band", int'(bus.dark), 1);
        amb(95); amb(95); amb(95);
        chk("dark_off2", int'(bus.dark), 0);
        amb(50); idle(10, 1'b0); amb(50); idle(5, 1'b0);
        chk("gap_pre", int'(bus.dark), 0);
        amb(50);
        chk("gap_confirm", int'(bus.dark), 1);

        // 6: one-cycle reset in HOLD with two of three off-samples counted
        idle(8, 1'b1);
        wait_hold("mid_hold_enter");
        amb(95); amb(95);
        chk("mid_pre_dark", int'(bus.dark), 1);
        step(1'b0, 1'b0, 0, 1'b0);
        chk("mid_rst_mov", int'(bus.movement), 0);
        chk("mid_rst_dark", int'(bus.dark), 0);
        chk("mid_rst_occ", int'(bus.occ_state), 0);
        amb(50); amb(50);
        chk("mid_dark_2", int'(bus.dark), 0);
        amb(50);
        chk("mid_dark_3", int'(bus.dark), 1);
        idle(4, 1'b0);
        chk("mid_stay_idle", int'(bus.occ_state), 0);

        // Random soak against the model
        cur_pir = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 6) == 0) cur_pir = ~cur_pir;
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      lvl = int'($urandom_range(0, 255));
            else if (sel == 1) lvl = int'($urandom_range(ON_LVL - 3, ON_LVL + 2));
            else               lvl = int'($urandom_range(OFF_LVL - 2, OFF_LVL + 3));
            step(($urandom_range(0, 299) != 0), cur_pir, lvl, 1'($urandom_range(0, 1)));
        end

        idle(2, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
